// File: rtl/ssd_bcd_counter.sv
// Multi-digit BCD up/down counter with prescaler, clear, load, wrap pulse and active-low 7-seg decode.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module ssd_bcd_counter #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned DIV        = 50000000,
  parameter int unsigned DIV_W      = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    wrap
);

  localparam int unsigned CW = 4 * NUM_DIGITS;
  localparam int unsigned HW = 7 * NUM_DIGITS;
  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(DIV - 1);

  logic [CW-1:0]    count_q, count_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             step;
  logic [CW:0]      stepped;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Ripple one step through all digits; MSB of result is the terminal-count carry/borrow.
  function automatic logic [CW:0] bcd_step(input logic [CW-1:0] c, input logic dir_up);
    logic [CW-1:0] r;
    logic          carry;
    logic [3:0]    dig;
    r     = c;
    carry = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      dig = c[4*k +: 4];
      if (carry) begin
        if (dir_up) begin
          if (dig == 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = dig + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            r[4*k +: 4] = 4'd9;
          end else begin
            r[4*k +: 4] = dig - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    bcd_step = {carry, r};
  endfunction

  function automatic logic [HW-1:0] decode_all(input logic [CW-1:0] c);
    logic [HW-1:0] h;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic lead;
    h    = '0;
    lead = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      lead = lead & (c[4*k +: 4] == 4'd0);
      h[7*k +: 7] = (k != 0 && lead) ? 7'b1111111 : seg7(c[4*k +: 4]);
    end
`else
    h = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      h[7*k +: 7] = seg7(c[4*k +: 4]);
    end
`endif
    decode_all = h;
  endfunction

  assign stepped = bcd_step(count_q, up);

  // Next state: clear beats load beats prescaled step.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    step    = 1'b0;
    if (clr) begin
      count_d = '0;
      presc_d = '0;
    end else if (load) begin
      presc_d = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        count_d[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd9 : load_val[4*k +: 4];
      end
    end else if (en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end
    if (step) begin
      count_d = stepped[CW-1:0];
      wrap_d  = stepped[CW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign hex   = decode_all(count_q);

endmodule

// File: doc/ssd_bcd_counter.md
Name: ssd_bcd_counter

Overview:
- Parametrised multi-digit BCD counter with built-in active-low seven-segment decoders; generalises the single-digit HEX0 decoder to NUM_DIGITS digits.
- Adds a clock-enable prescaler, up/down counting, synchronous clear, parallel load and a wrap pulse.
- Sits between board clock/switch logic and the HEXn display pins.

Parameters:
- NUM_DIGITS, 2, number of BCD digits and HEX displays driven (1..8).
- DIV, 50000000, clock cycles per count step; DIV=1 steps every enabled cycle.
- DIV_W, 26, prescaler width; must satisfy 2^DIV_W >= DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  count enable; gates prescaler and stepping.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous parallel load.
- load_val  input  4*NUM_DIGITS  BCD load value; digit k at [4k+3:4k].
- count  output  4*NUM_DIGITS  registered BCD count; digit 0 is least significant.
- hex  output  7*NUM_DIGITS  active-low segments; digit k at [7k+6:7k], bit order g..a (bit 6 = g, bit 0 = a).
- wrap  output  1  one-cycle pulse on a terminal-count rollover.

Behaviour:
- Reset (rst_n=0 at a clk edge): count=0 on all digits, prescaler=0, wrap=0. hex then shows "0" on every digit (1000000 per digit, without the optional feature).
- Priority at each edge: rst_n, then clr, then load, then step.
- clr=1: count=0, prescaler=0, wrap=0.
- load=1: each digit takes load_val; any digit value >9 is forced to 9. Prescaler resets to 0. wrap=0. No step occurs that cycle.
- Prescaler:
  - Counts 0..DIV-1 only while en=1.
  - step = en & (prescaler == DIV-1); prescaler returns to 0 on step.
  - en=0 holds the prescaler value; it does not reset.
- Step up:
  - Digit 0 increments.
  - A digit at 9 goes to 0 and carries into the next digit (ripple within the same cycle).
  - All digits at 9: all become 0 and wrap=1 for exactly one cycle.
- Step down:
  - Digit 0 decrements.
  - A digit at 0 goes to 9 and borrows from the next digit.
  - All digits at 0: all become 9 and wrap=1.
- wrap is registered. It is asserted the same edge count rolls over and is 0 on every other cycle.
- Direction change mid-count takes effect on the next step. There is no effect on the prescaler.
- hex is a combinational decode of the count register: it changes in the same cycle as count, with no added latency.
- Per-digit encoding (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10..15 cannot be reached; the decoder maps them to 1111111 (blank).
- NUM_DIGITS=1: wrap fires at 9->0 (up) and 0->9 (down).

Optional Feature:
- Macro SSD_LEADING_ZERO_BLANK_EN.
- Defined: any digit k>0 that is 0, with all higher digits also 0, drives 1111111 (blank). Digit 0 is never blanked. Example with NUM_DIGITS=3 and count 007: digits 2 and 1 are blank, digit 0 shows 7.
- Undefined: every digit is always decoded, including leading zeros.
- count and wrap are identical in both builds.

Test Plan:
- Reset / up-count wrap (NUM_DIGITS=2, DIV=1):
  - Assert rst_n=0 for 2 cycles -> count=0x00, hex=14'b1000000_1000000, wrap=0.
  - Then en=1, up=1 for 100 cycles -> count sequences 00..99, then 00; wrap=1 only on the 99->00 cycle.
- Down borrow: load_val=0x10, load=1, then en=1, up=0 -> count 10, 09, 08.
  - At 09, hex[6:0]=0010000 and hex[13:7]=1000000.
  - From 00, the next step gives 99 with wrap=1.
- Prescaler (DIV=4):
  - en=1 -> count advances every 4th cycle.
  - Drop en for 3 cycles mid-period -> the step is delayed by exactly 3 cycles.
- Priority and load saturation:
  - Assert clr=1 and load=1 with load_val=0x45 together -> count=00.
  - load_val=0xF3 alone -> count=0x93.
  - Step and load in the same cycle -> count equals the loaded value only.
- Reset mid-operation: rst_n=0 while prescaler=2 and count=57 (DIV=4) -> count=00. The next step occurs 4 enabled cycles after rst_n=1.
- Leading zero blanking: build with SSD_LEADING_ZERO_BLANK_EN, NUM_DIGITS=3, load 0x007 -> hex=21'b1111111_1111111_1111000.
  - Load 0x000 -> upper two digits blank, digit 0 shows 1000000.
  - Without the macro, 0x007 -> hex=1000000_1000000_1111000.
